rom_loader: RTL and testbench

Writer-side counterpart to the instruction ROM: streams a Hack program into the 16-bit instruction memory through its write port.
- Accepts a byte stream over a valid/ready handshake.
- Stream format: 16-bit word count header, then big-endian instruction words.
- Assembles each word and issues one-cycle write strobes at sequential addresses.
- Holds the CPU in reset until loading completes.

---
 rtl/hack_pkg.sv | 25 ++
 rtl/rom_loader_if.sv | 28 ++
 rtl/rom_loader_byte_pack.sv | 39 +++
 rtl/rom_loader.sv | 176 +++++++++++++++++
 tb/tb_rom_loader.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack ROM loader: word/byte widths, memory depth
// and the loader state encoding.
package hack_pkg;

  localparam int WORD_W    = 16;
  localparam int BYTE_W    = 8;
  localparam int ROM_DEPTH = 32768;

  // Loader states. CSUM_HI/CSUM_LO are only reachable when the checksum
  // option is compiled in.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    HDR_HI  = 4'd1,
    HDR_LO  = 4'd2,
    CHECK   = 4'd3,
    DATA_HI = 4'd4,
    DATA_LO = 4'd5,
    WRITE   = 4'd6,
    CSUM_HI = 4'd7,
    CSUM_LO = 4'd8,
    DONE    = 4'd9,
    ERROR   = 4'd10
  } state_e;

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input and instruction-memory write port of the ROM loader.
//
// Handshake: a byte moves on a rising clk edge where in_valid && in_ready.
// The host holds in_data stable while in_valid is high and not yet accepted;
// in_ready depends only on loader state, never on in_valid. wr_en is a
// one-cycle strobe with wr_addr/wr_data stable during that cycle.
interface rom_loader_if #(
  parameter int ADDR_W = 15
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  // Host side: produces the byte stream and observes the memory writes.
  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/rom_loader_byte_pack.sv
// Big-endian byte-to-word assembler. The high byte is parked in a holding
// register until the low byte arrives, so a stalled stream keeps the partial
// word indefinitely.
module rom_loader_byte_pack
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hi_en,
  input  logic              lo_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_o
);

  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [WORD_W-1:0] word_q, word_d;

  // Capture the high byte, then publish the full word on the low byte.
  always_comb begin
    hi_d   = hi_q;
    word_d = word_q;
    if (hi_en) hi_d = byte_in;
    if (lo_en) word_d = {hi_q, byte_in};
  end

  // Holding and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      word_q <= '0;
    end else begin
      hi_q   <= hi_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/rom_loader.sv
// Hack ROM loader: receives a 16-bit word-count header followed by
// big-endian instruction words over a byte stream and writes them to
// sequential instruction-memory addresses, holding the CPU in reset until a
// load completes. Optional build macro ROM_LOADER_CHECKSUM_EN appends a
// big-endian 16-bit checksum (mod-2^16 sum of the data words) to the stream.
module rom_loader
  import hack_pkg::*;
#(
  parameter int SIZE   = ROM_DEPTH,
  parameter int ADDR_W = $clog2(SIZE)
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  rom_loader_if.slave bus,
  output logic   cpu_hold,
  output logic   busy,
  output logic   done,
  output logic   error,
  output state_e dbg_state
);

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              pack_hi, pack_lo;
  logic [15:0]       word;
  logic              xfer;
  logic              last_word;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0]       csum_q, csum_d;
  logic [7:0]        csum_hi_q, csum_hi_d;
`endif

  assign xfer      = bus.in_valid && bus.in_ready;
  // Written addresses run 0..count-1, so the current write is the last one
  // when addr+1 reaches count.
  assign last_word = (32'(wr_addr_q) + 32'd1) == 32'(count_q);

  rom_loader_byte_pack u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .hi_en   (pack_hi),
    .lo_en   (pack_lo),
    .byte_in (bus.in_data),
    .word_o  (word)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wr_addr_q <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
      csum_hi_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
      csum_hi_q <= csum_hi_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    pack_hi   = 1'b0;
    pack_lo   = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
    csum_hi_d = csum_hi_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d   = HDR_HI;
          wr_addr_d = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      HDR_HI: begin
        if (xfer) begin
          count_d = {bus.in_data, count_q[7:0]};
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (xfer) begin
          count_d = {count_q[15:8], bus.in_data};
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (32'(count_q) > 32'(SIZE)) begin
          state_d = ERROR;
        end else if (count_q == 16'd0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          state_d = CSUM_HI;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA_HI;
        end
      end
      DATA_HI: begin
        if (xfer) begin
          pack_hi = 1'b1;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (xfer) begin
          pack_lo = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
        csum_d    = csum_q + word;
        state_d   = last_word ? CSUM_HI : DATA_HI;
`else
        state_d   = last_word ? DONE : DATA_HI;
`endif
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      CSUM_HI: begin
        if (xfer) begin
          csum_hi_d = bus.in_data;
          state_d   = CSUM_LO;
        end
      end
      CSUM_LO: begin
        if (xfer) begin
          state_d = ({csum_hi_q, bus.in_data} == csum_q) ? DONE : ERROR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state; done/error stay set while the
  // FSM rests in DONE/ERROR, which makes them sticky until the next start.
  always_comb begin
    bus.in_ready = 1'b0;
    busy         = 1'b0;
    case (state_q)
      HDR_HI, HDR_LO, DATA_HI, DATA_LO: bus.in_ready = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
      CSUM_HI, CSUM_LO:                 bus.in_ready = 1'b1;
`endif
      default:                          bus.in_ready = 1'b0;
    endcase
    if (state_q != IDLE && state_q != DONE && state_q != ERROR) busy = 1'b1;
    bus.wr_en   = (state_q == WRITE);
    bus.wr_addr = wr_addr_q;
    bus.wr_data = word;
    done        = (state_q == DONE);
    error       = (state_q == ERROR);
    cpu_hold    = (state_q != DONE);
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: random byte-stream loads with
// scoreboarded memory writes. Honours ROM_LOADER_CHECKSUM_EN when defined.
module tb_rom_loader;
  import hack_pkg::*;

  localparam int SIZE   = 32768;
  localparam int ADDR_W = 15;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   start;
  logic   cpu_hold, busy, done, error;
  state_e dbg_state;

  rom_loader_if #(.ADDR_W(ADDR_W)) bus();

  rom_loader #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  logic [30:0] exp_q[$];
  logic [15:0] words_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.wr_en === 1'b1) begin
        logic [30:0] e;
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0h:%0h expected=none", bus.wr_addr, bus.wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr_data", {1'b0, bus.wr_addr, bus.wr_data}, {1'b0, e});
        end
      end
    end
  endtask

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Idle for a random gap (randomly pulsing start, which a busy loader must
  // ignore), then present one byte until it is accepted.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int budget;
    gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    bus.in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
    end
    start        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    budget       = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        break;
      end
      budget++;
      if (budget > 100) begin
        checks++;
        failures++;
        $display("FAIL byte_accept_timeout actual=not_ready expected=ready byte=%0h", b);
        @(posedge clk); #1;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Reference model: header hdr, then the first n_send words of words_q;
  // word i must land at address i. The trailing checksum is sent (offset by
  // csum_delta) only when the full stream was sent.
  task automatic run_load(input logic [15:0] hdr, input int n_send, input int max_gap,
                          input logic [15:0] csum_delta);
    logic [15:0] sum;
    sum = 16'd0;
    send_byte(hdr[15:8], max_gap);
    send_byte(hdr[7:0], max_gap);
    if (32'(hdr) > SIZE) return;
    for (int i = 0; i < n_send; i++) begin
      exp_q.push_back({15'(i), words_q[i]});
      sum = sum + words_q[i];
      send_byte(words_q[i][15:8], max_gap);
      send_byte(words_q[i][7:0], max_gap);
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    if (n_send == int'(hdr)) begin
      sum = sum + csum_delta;
      send_byte(sum[15:8], max_gap);
      send_byte(sum[7:0], max_gap);
    end
`else
    if (csum_delta != 16'd0) sum = sum + csum_delta;
`endif
  endtask

  task automatic wait_end();
    int cyc;
    cyc = 0;
    while (!(done || error) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!(done || error)) begin
      checks++;
      failures++;
      $display("FAIL end_timeout actual=busy expected=done_or_error");
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back(16'($urandom_range(65535, 0)));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
  endtask

  // ---------------- main sequence ----------------
  task automatic main_seq();
    int base;
    int budget;
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed three-word load.
    words_q = '{16'h1234, 16'hABCD, 16'h0007};
    base = wr_cnt;
    pulse_start();
    run_load(16'd3, 3, 0, 16'd0);
    wait_end();
    chk("basic_done", done, 1);
    chk("basic_error", error, 0);
    chk("basic_cpu_hold", cpu_hold, 0);
    chk("basic_busy", busy, 0);
    chk("basic_wr_count", wr_cnt - base, 3);
    chk("basic_next_addr", bus.wr_addr, 3);

    // Empty program.
    words_q.delete();
    base = wr_cnt;
    pulse_start();
    chk("hdr0_started_busy", busy, 1);
    chk("hdr0_done_cleared", done, 0);
    chk("hdr0_cpu_hold", cpu_hold, 1);
    run_load(16'd0, 0, 0, 16'd0);
`ifdef ROM_LOADER_CHECKSUM_EN
    wait_end();
    chk("hdr0_done", done, 1);
`else
    chk("hdr0_not_yet_done", done, 0);
    @(posedge clk); #1;
    chk("hdr0_done", done, 1);
`endif
    chk("hdr0_wr_count", wr_cnt - base, 0);

    // Oversized header, then recovery.
    base = wr_cnt;
    pulse_start();
    run_load(16'h8001, 0, 0, 16'd0);
    wait_end();
    chk("big_error", error, 1);
    chk("big_done", done, 0);
    chk("big_in_ready", bus.in_ready, 0);
    chk("big_cpu_hold", cpu_hold, 1);
    chk("big_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("big_error_sticky", error, 1);
    chk("big_wr_count", wr_cnt - base, 0);
    pulse_start();
    chk("recover_error_cleared", error, 0);
    chk("recover_in_ready", bus.in_ready, 1);
    chk("recover_busy", busy, 1);

    // Sixteen words gap-free, then the same words with random gaps.
    rand_words(16);
    base = wr_cnt;
    run_load(16'd16, 16, 0, 16'd0);
    wait_end();
    chk("w16_nogap_done", done, 1);
    chk("w16_nogap_count", wr_cnt - base, 16);
    base = wr_cnt;
    pulse_start();
    run_load(16'd16, 16, 5, 16'd0);
    wait_end();
    chk("w16_gap_done", done, 1);
    chk("w16_gap_count", wr_cnt - base, 16);
    chk("w16_gap_q_empty", exp_q.size(), 0);

    // Asynchronous reset after five of ten words.
    rand_words(10);
    base = wr_cnt;
    pulse_start();
    run_load(16'd10, 5, 2, 16'd0);
    budget = 0;
    while (wr_cnt < base + 5 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("midrst_writes_before", wr_cnt - base, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    chk("midrst_q_empty", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = wr_cnt;
    pulse_start();
    run_load(16'd10, 10, 2, 16'd0);
    wait_end();
    chk("reload_done", done, 1);
    chk("reload_count", wr_cnt - base, 10);

`ifdef ROM_LOADER_CHECKSUM_EN
    words_q = '{16'h0001, 16'hFFFF};
    base = wr_cnt;
    pulse_start();
    run_load(16'd2, 2, 0, 16'd0);
    wait_end();
    chk("csum_good_done", done, 1);
    chk("csum_good_error", error, 0);
    base = wr_cnt;
    pulse_start();
    run_load(16'd2, 2, 0, 16'd1);
    wait_end();
    chk("csum_bad_error", error, 1);
    chk("csum_bad_done", done, 0);
    chk("csum_bad_writes", wr_cnt - base, 2);
`endif

    // Random short loads with random gaps.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(6, 1);
      rand_words(n);
      base = wr_cnt;
      pulse_start();
      run_load(16'(n), n, 3, 16'd0);
      wait_end();
      chk("rand_done", done, 1);
      chk("rand_count", wr_cnt - base, n);
    end
    chk("final_q_empty", exp_q.size(), 0);
  endtask

  // ---------------- run and report ----------------
  initial begin
    fork
      monitor_loop();
      main_seq();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
